knn_ctrl: RTL and testbench
===========================

KNN_CTRL -- requirements
Module: knn_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: training-memory address width and point-count width.
REQ-002 Parameter DATA_W, default 32: width of a packed point word.
REQ-003 Parameter LABEL_W, default 8: label field width, held in bits [DATA_W-1 -: LABEL_W] of each training word.
REQ-004 Port clk, input, 1: single clock; every register updates on the rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port cfg_start, input, 1: single-cycle job start request.
REQ-007 Port cfg_abort, input, 1: cancels the running job.
REQ-008 Port cfg_base, input, ADDR_W: first training-word address; sampled at accepted start.
REQ-009 Port cfg_count, input, ADDR_W: number of training points; sampled at accepted start.
REQ-010 Port test_point, input, DATA_W: test point; sampled at accepted start.
REQ-011 Port mem_req, output, 1: training-memory read request.
REQ-012 Port mem_addr, output, ADDR_W: read address.
REQ-013 Port mem_ack, input, 1: read data valid on mem_rdata this cycle.
REQ-014 Port mem_rdata, input, DATA_W: training word.
REQ-015 Port core_clear, output, 1: one-cycle pulse that clears the core neighbour list.
REQ-016 Port core_a, output, DATA_W: test point presented to the core.
REQ-017 Port core_b, output, DATA_W: training word with the label field zeroed.
REQ-018 Port core_label, output, LABEL_W: label field of the training word.
REQ-019 Port core_valid, output, 1: core operand valid.
REQ-020 Port core_ready, input, 1: core accepts the operand.
REQ-021 Port busy, output, 1: job in progress.
REQ-022 Port done, output, 1: one-cycle pulse when a job completes normally.
REQ-023 Port processed, output, ADDR_W: number of points transferred to the core in the current or last job.

Function
REQ-024 The FSM SHALL have states IDLE, CLEAR, FETCH, FEED, FIN.
REQ-025 In IDLE, cfg_start=1 SHALL register cfg_base, cfg_count and test_point, clear processed and the index, and enter CLEAR; cfg_start outside IDLE SHALL be ignored.
REQ-026 CLEAR SHALL last exactly one cycle with core_clear=1, then enter FIN if count=0 and FETCH otherwise.
REQ-027 In FETCH, mem_req SHALL be 1 and mem_addr SHALL be (base+index) mod 2^ADDR_W, held stable until mem_ack.
REQ-028 When mem_ack=1 in FETCH, the FSM SHALL latch mem_rdata into the operand register and enter FEED; mem_ack outside FETCH SHALL be ignored.
REQ-029 In FEED, core_valid SHALL be 1 with core_a, core_b and core_label stable until core_ready=1, which completes the transfer.
REQ-030 On transfer, processed and index SHALL increment by 1 and the FSM SHALL enter FIN if index+1 equals count, else FETCH; the next mem_req SHALL therefore assert the following cycle.
REQ-031 FIN SHALL last one cycle with done=1, then enter IDLE.
REQ-032 busy SHALL be 1 in CLEAR, FETCH, FEED and FIN, and 0 in IDLE.
REQ-033 cfg_abort=1 in any busy state SHALL force IDLE on the next edge with no done, and SHALL take priority over a mem_ack or core_ready in the same cycle (data discarded, processed not incremented).
REQ-034 processed SHALL hold its value after done or abort until the next accepted start.
REQ-035 Address arithmetic SHALL wrap modulo 2^ADDR_W; count=2^ADDR_W-1 SHALL be supported.
REQ-036 mem_req, core_valid and core_clear SHALL never be asserted in the same cycle.
REQ-037 Minimum cost per point SHALL be 2 cycles (mem_ack and core_ready both immediate).

Reset
REQ-038 rst=1 SHALL, on the next edge, set the state to IDLE and set busy, done, mem_req, core_valid, core_clear, processed, mem_addr, core_a, core_b and core_label to 0, regardless of the current state.
REQ-039 While rst=1, cfg_start SHALL be ignored.

Verification
REQ-040 Bench: base=0x010, count=3, memory and core responding immediately -> core_clear at cycle 1; mem_addr 0x010, 0x011, 0x012; 3 core_valid transfers; done 1 cycle after the last transfer; processed=3.
REQ-041 Bench: count=0 -> CLEAR then FIN; done asserts 2 cycles after start; no mem_req; processed=0.
REQ-042 Bench: base=0x3FE, count=4, ADDR_W=10 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-043 Bench: mem_ack delayed 3 cycles and core_ready delayed 2 cycles -> mem_addr and core operands stay stable throughout; a word 0xAB123456 gives core_label=0xAB and core_b=0x00123456.
REQ-044 Bench: abort coincident with core_ready on the 2nd point -> IDLE next cycle, processed=1, no done; a new cfg_start is then accepted.
REQ-045 Bench: rst asserted in FEED -> all outputs 0 the next cycle; cfg_start during rst is ignored; cfg_start after rst starts a clean job.

Source files
------------

// File: rtl/knn_ctrl.sv
// knn_ctrl: sequences one k-NN job, streaming training words from
// memory into the distance core and pairing each with the test point.
module knn_ctrl #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int LABEL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start,
   input  logic              cfg_abort,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W-1:0] cfg_count,
   input  logic [DATA_W-1:0] test_point,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              core_clear,
   output logic [DATA_W-1:0] core_a,
   output logic [DATA_W-1:0] core_b,
   output logic [LABEL_W-1:0] core_label,
   output logic              core_valid,
   input  logic              core_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] processed
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FETCH,
      FEED,
      FIN
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] count_q;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] idx_nxt;
   logic [ADDR_W-1:0] proc_q;
   logic [DATA_W-1:0] test_q;
   logic [DATA_W-1:0] word_q;

   logic start_ok;
   logic fetch_ok;
   logic xfer_ok;
   logic last_xfer;

   // Abort outranks a same-cycle ack/ready: the data is simply dropped.
   assign start_ok  = (state_q == IDLE) && cfg_start;
   assign fetch_ok  = (state_q == FETCH) && mem_ack && !cfg_abort;
   assign xfer_ok   = (state_q == FEED) && core_ready && !cfg_abort;
   assign idx_nxt   = idx_q + ADDR_W'(1);
   assign last_xfer = (idx_nxt == count_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            state_d = (count_q == '0) ? FIN : FETCH;
         end
         FETCH: begin
            if (mem_ack) begin
               state_d = FEED;
            end
         end
         FEED: begin
            if (core_ready) begin
               state_d = last_xfer ? FIN : FETCH;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (cfg_abort && (state_q != IDLE)) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base_q  <= '0;
         count_q <= '0;
         idx_q   <= '0;
         proc_q  <= '0;
         test_q  <= '0;
         word_q  <= '0;
      end else begin
         if (start_ok) begin
            base_q  <= cfg_base;
            count_q <= cfg_count;
            test_q  <= test_point;
            idx_q   <= '0;
            proc_q  <= '0;
         end
         if (fetch_ok) begin
            word_q <= mem_rdata;
         end
         if (xfer_ok) begin
            idx_q  <= idx_nxt;
            proc_q <= proc_q + ADDR_W'(1);
         end
      end
   end

   always_comb begin
      mem_req    = 1'b0;
      mem_addr   = '0;
      core_clear = 1'b0;
      core_valid = 1'b0;
      done       = 1'b0;
      busy       = 1'b1;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
         end
         CLEAR: begin
            core_clear = 1'b1;
         end
         FETCH: begin
            mem_req  = 1'b1;
            mem_addr = base_q + idx_q;
         end
         FEED: begin
            core_valid = 1'b1;
         end
         FIN: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign core_a     = test_q;
   assign core_b     = {{LABEL_W{1'b0}}, word_q[DATA_W-LABEL_W-1:0]};
   assign core_label = word_q[DATA_W-1 -: LABEL_W];
   assign processed  = proc_q;

endmodule

// File: tb/tb_knn_ctrl.sv
// tb_knn_ctrl: scoreboard bench for knn_ctrl with a memory model and
// a core model whose response latencies are set per scenario.
module tb_knn_ctrl;

   logic        clk;
   logic        rst;
   logic        cfg_start;
   logic        cfg_abort;
   logic [9:0]  cfg_base;
   logic [9:0]  cfg_count;
   logic [31:0] test_point;
   logic        mem_req;
   logic [9:0]  mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        core_clear;
   logic [31:0] core_a;
   logic [31:0] core_b;
   logic [7:0]  core_label;
   logic        core_valid;
   logic        core_ready;
   logic        busy;
   logic        done;
   logic [9:0]  processed;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:1023];
   logic [9:0]  exp_addr_q [$];
   logic [31:0] exp_word_q [$];
   logic [31:0] tp_exp;

   knn_ctrl #(.ADDR_W(10), .DATA_W(32), .LABEL_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_start  (cfg_start),
      .cfg_abort  (cfg_abort),
      .cfg_base   (cfg_base),
      .cfg_count  (cfg_count),
      .test_point (test_point),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .core_clear (core_clear),
      .core_a     (core_a),
      .core_b     (core_b),
      .core_label (core_label),
      .core_valid (core_valid),
      .core_ready (core_ready),
      .busy       (busy),
      .done       (done),
      .processed  (processed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Pushes the expected address/word stream, then pulses cfg_start.
   task automatic do_start(input logic [9:0] b, input logic [9:0] n,
                           input logic [31:0] tp);
      logic [9:0] a;
      exp_addr_q.delete();
      exp_word_q.delete();
      for (int i = 0; i < int'(n); i++) begin
         a = b + 10'(i);
         exp_addr_q.push_back(a);
         exp_word_q.push_back(mem[a]);
      end
      tp_exp     = tp;
      cfg_base   = b;
      cfg_count  = n;
      test_point = tp;
      cfg_start  = 1'b1;
      step();
      cfg_start  = 1'b0;
      cfg_base   = ~b;
      cfg_count  = ~n;
      test_point = ~tp;
   endtask

   task automatic run_job(input int n, input int ack_dly, input int rdy_dly,
                          input int abort_at, input bit noise,
                          output int done_cyc);
      int wait_m;
      int wait_c;
      int xfer;
      int last_cyc;
      int limit;
      int exp_cyc;
      bit in_fetch;
      bit in_feed;
      bit aborting;
      bit finished;
      logic [9:0]  a_hold;
      logic [31:0] w_hold;
      wait_m = 0; wait_c = 0; xfer = 0; last_cyc = 0; done_cyc = -1;
      in_fetch = 0; in_feed = 0; aborting = 0; finished = 0;
      a_hold = '0; w_hold = '0;
      limit = 20 + n * (ack_dly + rdy_dly + 4);
      for (int cyc = 1; cyc <= limit && !finished; cyc++) begin
         mem_ack    = 1'b0;
         core_ready = 1'b0;
         cfg_abort  = 1'b0;
         cfg_start  = 1'b0;
         mem_rdata  = $urandom;
         checks++;
         if (int'(mem_req) + int'(core_valid) + int'(core_clear) > 1) begin
            errors++;
            $display("FAIL excl: cyc %0d req=%b valid=%b clear=%b",
                     cyc, mem_req, core_valid, core_clear);
         end
         checks++;
         if (core_clear !== (cyc == 1)) begin
            errors++;
            $display("FAIL clear_pulse: cyc %0d got %b want %b",
                     cyc, core_clear, (cyc == 1));
         end
         if (mem_req) begin
            checks++;
            if (!in_fetch) begin
               in_fetch = 1;
               wait_m = 0;
               if (exp_addr_q.size() == 0) begin
                  errors++;
                  $display("FAIL extra_req: cyc %0d got addr %h want none",
                           cyc, mem_addr);
               end else begin
                  a_hold = exp_addr_q.pop_front();
                  if (mem_addr !== a_hold) begin
                     errors++;
                     $display("FAIL addr: got %h want %h", mem_addr, a_hold);
                  end
               end
            end else if (mem_addr !== a_hold) begin
               errors++;
               $display("FAIL addr_stable: got %h want %h", mem_addr, a_hold);
            end
            if (wait_m == ack_dly) begin
               mem_ack = 1'b1;
               mem_rdata = mem[mem_addr];
               in_fetch = 0;
            end else begin
               wait_m++;
               if (noise) cfg_start = 1'b1;
            end
         end
         if (core_valid) begin
            checks++;
            if (!in_feed) begin
               in_feed = 1;
               wait_c = 0;
               if (exp_word_q.size() == 0) begin
                  errors++;
                  $display("FAIL extra_valid: cyc %0d got %h want none",
                           cyc, core_b);
               end else begin
                  w_hold = exp_word_q.pop_front();
               end
            end
            if ({core_a, core_b, core_label} !==
                {tp_exp, 8'h00, w_hold[23:0], w_hold[31:24]}) begin
               errors++;
               $display("FAIL operand: got a=%h b=%h l=%h want a=%h b=%h l=%h",
                        core_a, core_b, core_label, tp_exp,
                        {8'h00, w_hold[23:0]}, w_hold[31:24]);
            end
            if (wait_c == rdy_dly) begin
               core_ready = 1'b1;
               last_cyc = cyc;
               in_feed = 0;
               if (xfer == abort_at) begin
                  cfg_abort = 1'b1;
                  aborting = 1;
               end
               xfer++;
            end else begin
               wait_c++;
               if (noise) begin
                  mem_ack = 1'b1;
                  cfg_start = 1'b1;
               end
            end
         end
         if (done) begin
            done_cyc = cyc;
            exp_cyc = (n == 0) ? 2 : last_cyc + 1;
            checks++;
            if (processed !== 10'(n) || xfer != n || cyc != exp_cyc) begin
               errors++;
               $display("FAIL done: got proc=%0d xfer=%0d cyc=%0d want %0d %0d %0d",
                        processed, xfer, cyc, n, n, exp_cyc);
            end
            finished = 1;
         end
         step();
         if (finished) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
               errors++;
               $display("FAIL fin_len: got busy=%b done=%b want 0 0", busy, done);
            end
         end else if (aborting) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || processed !== 10'(abort_at)) begin
               errors++;
               $display("FAIL abort: got busy=%b done=%b proc=%0d want 0 0 %0d",
                        busy, done, processed, abort_at);
            end
            finished = 1;
         end
      end
      mem_ack = 1'b0;
      core_ready = 1'b0;
      cfg_abort = 1'b0;
      cfg_start = 1'b0;
      if (!finished) begin
         errors++;
         $display("FAIL timeout: got no done within %0d cycles want done", limit);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cfg_start = 1'b1;
      cfg_count = 10'd3;
      repeat (3) step();
      checks++;
      if ({busy, done, mem_req, core_valid, core_clear, processed, mem_addr,
           core_a, core_b, core_label} !== '0) begin
         errors++;
         $display("FAIL reset_outs: got busy=%b done=%b req=%b val=%b clr=%b proc=%h addr=%h a=%h b=%h l=%h want all 0",
                  busy, done, mem_req, core_valid, core_clear, processed,
                  mem_addr, core_a, core_b, core_label);
      end
      rst = 1'b0;
      cfg_start = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || core_clear !== 1'b0) begin
         errors++;
         $display("FAIL reset_start: got busy=%b clr=%b want 0 0", busy, core_clear);
      end
   endtask

   task automatic test_basic();
      int dc;
      do_start(10'h010, 10'd3, 32'h1234_5678);
      run_job(3, 0, 0, -1, 0, dc);
      checks++;
      if (dc != 8) begin
         errors++;
         $display("FAIL basic_rate: got done cyc %0d want 8", dc);
      end
   endtask

   task automatic test_zero();
      int dc;
      do_start(10'h055, 10'd0, 32'hCAFE_0000);
      run_job(0, 0, 0, -1, 0, dc);
      checks++;
      if (processed !== 10'd0) begin
         errors++;
         $display("FAIL zero_proc: got %0d want 0", processed);
      end
   endtask

   task automatic test_wrap();
      int dc;
      do_start(10'h3FE, 10'd4, 32'h0F0F_0F0F);
      run_job(4, 0, 0, -1, 0, dc);
   endtask

   task automatic test_stall();
      int dc;
      mem[10'h200] = 32'hAB12_3456;
      do_start(10'h200, 10'd2, 32'h5555_AAAA);
      run_job(2, 3, 2, -1, 1, dc);
   endtask

   task automatic test_abort();
      int dc;
      do_start(10'h100, 10'd4, 32'h7777_0001);
      run_job(4, 0, 0, 1, 0, dc);
      step();
      checks++;
      if (done !== 1'b0 || processed !== 10'd1) begin
         errors++;
         $display("FAIL abort_hold: got done=%b proc=%0d want 0 1", done, processed);
      end
      do_start(10'h108, 10'd2, 32'h7777_0002);
      run_job(2, 1, 1, -1, 0, dc);
   endtask

   task automatic test_reset_feed();
      int dc;
      bit hit;
      hit = 0;
      do_start(10'h020, 10'd3, 32'h3333_4444);
      for (int c = 0; c < 20 && !hit; c++) begin
         if (core_valid && processed == 10'd1) begin
            hit = 1;
         end else begin
            mem_ack = mem_req;
            mem_rdata = mem[mem_addr];
            core_ready = core_valid && (processed == 10'd0);
            step();
         end
      end
      mem_ack = 1'b0;
      core_ready = 1'b0;
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL rst_feed_reach: got no FEED state want FEED");
      end
      rst = 1'b1;
      cfg_start = 1'b1;
      step();
      checks++;
      if ({busy, done, mem_req, core_valid, core_clear, processed, mem_addr,
           core_a, core_b, core_label} !== '0) begin
         errors++;
         $display("FAIL rst_feed: got busy=%b val=%b proc=%h a=%h b=%h l=%h want all 0",
                  busy, core_valid, processed, core_a, core_b, core_label);
      end
      step();
      rst = 1'b0;
      cfg_start = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_start_ign: got busy=%b want 0", busy);
      end
      do_start(10'h030, 10'd2, 32'h9999_0000);
      run_job(2, 0, 0, -1, 0, dc);
   endtask

   task automatic test_back_to_back();
      int dc;
      do_start(10'h2F0, 10'd5, 32'h1111_2222);
      run_job(5, 1, 0, -1, 1, dc);
      do_start(10'h2F3, 10'd3, 32'h4444_5555);
      run_job(3, 0, 1, -1, 1, dc);
   endtask

   task automatic test_max_count();
      int dc;
      do_start(10'h005, 10'h3FF, 32'hDEAD_BEEF);
      run_job(1023, 0, 0, -1, 0, dc);
      checks++;
      if (dc != 2 + 2 * 1023) begin
         errors++;
         $display("FAIL max_rate: got done cyc %0d want %0d", dc, 2 + 2 * 1023);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      rst = 1'b1;
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      cfg_base = '0;
      cfg_count = '0;
      test_point = '0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      core_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_zero();
      test_wrap();
      test_stall();
      test_abort();
      test_reset_feed();
      test_back_to_back();
      test_max_count();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
